// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the hazard-tracker entry type.
// Used by instr_classifier and hazard_tracker.
package mips_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [REG_ADDR_W-1:0] REG_RA = 5'd31;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] dest;
      logic                  is_load;
   } trk_entry_t;

endpackage

// File: rtl/instr_classifier.sv
// Combinational decode of a MIPS instruction into the register reads/writes
// the hazard tracker needs: source usage, destination and load flag.
module instr_classifier
   import mips_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic [31:0]       instr,
   output logic              uses_rs,
   output logic              uses_rt,
   output logic [ADDR_W-1:0] dest,
   output logic              has_dest,
   output logic              is_load
);

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [ADDR_W-1:0] rt;
   logic [ADDR_W-1:0] rd;
   logic              unused_bits;

   assign opcode      = instr[31:26];
   assign funct       = instr[5:0];
   assign rt          = ADDR_W'(instr[20:16]);
   assign rd          = ADDR_W'(instr[15:11]);
   assign unused_bits = ^{instr[25:21], instr[10:6]};

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      uses_rs  = 1'b0;
      uses_rt  = 1'b0;
      dest     = '0;
      has_dest = 1'b0;
      is_load  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            uses_rs = 1'b1;
            if (funct != FN_JR) begin
               uses_rt  = 1'b1;
               dest     = rd;
               has_dest = 1'b1;
            end
         end
         OP_LW: begin
            uses_rs  = 1'b1;
            dest     = rt;
            has_dest = 1'b1;
            is_load  = 1'b1;
         end
         OP_SW, OP_BEQ, OP_BNE: begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         OP_ADDI, OP_ORI: begin
            uses_rs  = 1'b1;
            dest     = rt;
            has_dest = 1'b1;
         end
         OP_LUI: begin
            dest     = rt;
            has_dest = 1'b1;
         end
         OP_JAL: begin
            dest     = ADDR_W'(REG_RA);
            has_dest = 1'b1;
         end
         OP_J: ;
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_tracker.sv
// Decode-stage hazard unit: tracks in-flight writers and produces the stall
// request and per-operand forward selects. Optional HAZARD_STATS_EN adds counters.
module hazard_tracker
   import mips_pkg::*;
#(
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int FW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   instr_d,
   input  logic          valid_d,
   input  logic          flush,
   output logic          stall,
   output logic [FW-1:0] fwd_a,
   output logic [FW-1:0] fwd_b,
   output logic          uses_rs,
   output logic          uses_rt
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   load_use_cnt
`endif
);

   logic              c_uses_rs, c_uses_rt, c_has_dest, c_is_load;
   logic [ADDR_W-1:0] c_dest, rs, rt;
   logic              stl_a, stl_b, issue;
   logic [FW-1:0]     sel_a, sel_b;
   trk_entry_t        new_entry;
   trk_entry_t [DEPTH:1] trk;

   assign rs = ADDR_W'(instr_d[25:21]);
   assign rt = ADDR_W'(instr_d[20:16]);

   instr_classifier #(.ADDR_W(ADDR_W)) u_classifier (
      .instr    (instr_d),
      .uses_rs  (c_uses_rs),
      .uses_rt  (c_uses_rt),
      .dest     (c_dest),
      .has_dest (c_has_dest),
      .is_load  (c_is_load)
   );

   // Walk oldest to youngest so the lowest matching stage has the last word.
   function automatic logic [FW:0] lookup(input logic used, input logic [ADDR_W-1:0] src,
                                          input trk_entry_t [DEPTH:1] t);
      logic          stl;
      logic [FW-1:0] sel;
      stl = 1'b0;
      sel = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (used && src != '0 && t[k].valid && t[k].dest == src) begin
            if (!t[k].is_load || k >= 1 + LOAD_LAT) begin
               sel = FW'(k);
               stl = 1'b0;
            end else begin
               sel = '0;
               stl = 1'b1;
            end
         end
      end
      return {stl, sel};
   endfunction

   always_comb begin
      {stl_a, sel_a} = lookup(c_uses_rs, rs, trk);
      {stl_b, sel_b} = lookup(c_uses_rt, rt, trk);
      stall   = !reset && valid_d && !flush && (stl_a || stl_b);
      fwd_a   = (reset || stall) ? '0 : sel_a;
      fwd_b   = (reset || stall) ? '0 : sel_b;
      uses_rs = c_uses_rs && !reset;
      uses_rt = c_uses_rt && !reset;
   end

   assign issue     = valid_d && !flush && !stall;
   assign new_entry = issue ? trk_entry_t'{valid: c_has_dest && c_dest != '0,
                                           dest: REG_ADDR_W'(c_dest), is_load: c_is_load}
                            : '0;

   always_ff @(posedge clk) begin
      // NOTE: the tracker is reset because its valid bits gate every match.
      if (reset) begin
         trk <= '0;
      end else begin
         // NOTE: nonblocking, so each stage takes its neighbour's pre-edge value.
         trk[1] <= new_entry;
         for (int k = 2; k <= DEPTH; k++) trk[k] <= trk[k-1];
      end
   end

`ifdef HAZARD_STATS_EN
   // Only load entries can be not-ready, so every stall is a load-use stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt    <= '0;
         load_use_cnt <= '0;
      end else if (stall) begin
         stall_cnt    <= stall_cnt + 32'd1;
         load_use_cnt <= load_use_cnt + 32'd1;
      end
   end
`else
   // Statistics disabled: no counter state is built.
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed, table-driven bench for hazard_tracker (LOAD_LAT 1 and 2 instances).
module tb_hazard_tracker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr_d = '0;
   logic        valid_d = 1'b0;
   logic        flush = 1'b0;

   logic       stall, uses_rs, uses_rt;
   logic [1:0] fwd_a, fwd_b;
   logic       stall2, uses_rs2, uses_rt2;
   logic [1:0] fwd_a2, fwd_b2;
`ifdef HAZARD_STATS_EN
   logic [31:0] sc1, lc1, sc2, lc2;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_tracker dut (
      .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .flush(flush),
      .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .uses_rs(uses_rs), .uses_rt(uses_rt)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(sc1), .load_use_cnt(lc1)
`endif
   );

   hazard_tracker #(.LOAD_LAT(2)) dut2 (
      .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .flush(flush),
      .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .uses_rs(uses_rs2), .uses_rt(uses_rt2)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(sc2), .load_use_cnt(lc2)
`endif
   );

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic        flush;
      logic        exp_stall;
      logic [1:0]  exp_a;
      logic [1:0]  exp_b;
      logic        exp_urs;
      logic        exp_urt;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 16'h0004};
   endfunction

   function automatic vec_t mk(input logic [31:0] instr, input logic v, input logic f,
                               input logic s, input int a, input int b,
                               input logic urs, input logic urt);
      vec_t r;
      r.instr = instr; r.valid = v; r.flush = f; r.exp_stall = s;
      r.exp_a = 2'(a); r.exp_b = 2'(b); r.exp_urs = urs; r.exp_urt = urt;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic [31:0] ins, input logic v, input logic f);
      @(negedge clk);
      instr_d = ins;
      valid_d = v;
      flush   = f;
      #1;
   endtask

   localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, JR = 6'b001000;

   initial begin
      // Rows run back to back after reset; each row's expectation depends on the rows before.
      vecs.push_back(mk(r_op(1, 2, 3, ADD),          1, 0, 0, 0, 0, 1, 1)); // 0  add $3,$1,$2
      vecs.push_back(mk(r_op(3, 3, 4, SUB),          1, 0, 0, 1, 1, 1, 1)); // 1  sub $4,$3,$3
      vecs.push_back(mk(i_op(6'b001000, 1, 7),       1, 0, 0, 0, 0, 1, 0)); // 2  addi $7,$1
      vecs.push_back(mk(32'h0,                       0, 0, 0, 0, 0, 1, 1)); // 3  bubble
      vecs.push_back(mk(i_op(6'b001101, 1, 7),       1, 0, 0, 0, 0, 1, 0)); // 4  ori $7,$1
      vecs.push_back(mk(r_op(7, 4, 8, ADD),          1, 0, 0, 1, 0, 1, 1)); // 5  add $8,$7,$4
      vecs.push_back(mk(r_op(8, 0, 0, JR),           1, 0, 0, 1, 0, 1, 0)); // 6  jr $8
      vecs.push_back(mk(i_op(6'b101011, 8, 7),       1, 0, 0, 2, 3, 1, 1)); // 7  sw $7,($8)
      vecs.push_back(mk(i_op(6'b000100, 8, 8),       1, 0, 0, 3, 3, 1, 1)); // 8  beq $8,$8
      vecs.push_back(mk(i_op(6'b001000, 1, 0),       1, 0, 0, 0, 0, 1, 0)); // 9  addi $0,$1
      vecs.push_back(mk(r_op(0, 0, 2, ADD),          1, 0, 0, 0, 0, 1, 1)); // 10 add $2,$0,$0
      vecs.push_back(mk(i_op(6'b001111, 2, 9),       1, 0, 0, 0, 0, 0, 0)); // 11 lui $9
      vecs.push_back(mk({6'b000011, 26'd0},          1, 0, 0, 0, 0, 0, 0)); // 12 jal
      vecs.push_back(mk(r_op(31, 9, 1, ADD),         1, 0, 0, 1, 2, 1, 1)); // 13 add $1,$31,$9
      vecs.push_back(mk({6'b000010, 5'd1, 21'd0},    1, 0, 0, 0, 0, 0, 0)); // 14 j
      vecs.push_back(mk(i_op(6'b100011, 1, 5),       1, 0, 0, 2, 0, 1, 0)); // 15 lw $5,($1)
      vecs.push_back(mk(r_op(5, 2, 6, ADD),          1, 0, 1, 0, 0, 1, 1)); // 16 load-use stall
      vecs.push_back(mk(r_op(5, 2, 6, ADD),          1, 0, 0, 2, 0, 1, 1)); // 17 forwarded from M
      vecs.push_back(mk(i_op(6'b100011, 6, 10),      1, 0, 0, 1, 0, 1, 0)); // 18 lw $10,($6)
      vecs.push_back(mk(r_op(10, 6, 12, ADD),        1, 1, 0, 0, 2, 1, 1)); // 19 flush beats stall
      vecs.push_back(mk(r_op(12, 10, 13, ADD),       1, 0, 0, 0, 2, 1, 1)); // 20 $12 never issued
      vecs.push_back(mk(i_op(6'b100011, 13, 15),     1, 0, 0, 1, 0, 1, 0)); // 21 lw $15,($13)
      vecs.push_back(mk(r_op(15, 0, 16, ADD),        0, 0, 0, 0, 0, 1, 1)); // 22 invalid, no stall
      vecs.push_back(mk(r_op(15, 15, 16, ADD),       1, 0, 0, 2, 2, 1, 1)); // 23 both from M

      // Reset holds outputs quiet even with a valid instruction present.
      step(r_op(1, 2, 3, ADD), 1, 0);
      check("reset stall", stall, 0);
      check("reset fwd_a", fwd_a, 0);
      check("reset fwd_b", fwd_b, 0);
      check("reset uses_rs", uses_rs, 0);
      check("reset uses_rt", uses_rt, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].instr, vecs[i].valid, vecs[i].flush);
         check($sformatf("row%0d stall", i),   stall,   vecs[i].exp_stall);
         check($sformatf("row%0d fwd_a", i),   fwd_a,   vecs[i].exp_a);
         check($sformatf("row%0d fwd_b", i),   fwd_b,   vecs[i].exp_b);
         check($sformatf("row%0d uses_rs", i), uses_rs, vecs[i].exp_urs);
         check($sformatf("row%0d uses_rt", i), uses_rt, vecs[i].exp_urt);
      end

      // Reset asserted during a load-use stall drops it in the same cycle.
      step(i_op(6'b100011, 1, 5), 1, 0);
      step(r_op(5, 2, 6, ADD), 1, 0);
      check("pre-reset stall", stall, 1);
      reset = 1'b1;
      #1;
      check("mid-stall reset stall", stall, 0);
      check("mid-stall reset fwd_a", fwd_a, 0);
      check("mid-stall reset uses_rs", uses_rs, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      step(r_op(5, 2, 6, ADD), 1, 0);
      check("post-reset tracker empty stall", stall, 0);
      check("post-reset tracker empty fwd_a", fwd_a, 0);

      // LOAD_LAT = 2: two stall cycles, then forward from W.
      step(i_op(6'b100011, 1, 5), 1, 0);
      step(r_op(5, 2, 6, ADD), 1, 0);
      check("ll1 stall cycle1", stall, 1);
      check("ll2 stall cycle1", stall2, 1);
      step(r_op(5, 2, 6, ADD), 1, 0);
      check("ll1 fwd_a after stall", fwd_a, 2);
      check("ll2 stall cycle2", stall2, 1);
      step(r_op(5, 2, 6, ADD), 1, 0);
      check("ll2 stall cycle3", stall2, 0);
      check("ll2 fwd_a", fwd_a2, 3);
      check("ll2 fwd_b", fwd_b2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
